// File: rtl/unified_mem_responder.sv
// Memory-side responder for the five-stage MIPS core: IMEM/DMEM storage,
// a boot loader that fills both memories from a valid/ready stream, and a sticky fault monitor.
module unified_mem_responder #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        load_sel,
  input  logic        load_last,
  input  logic [31:0] load_data,
  output logic        cpu_ena,
  input  logic [31:0] IMEM_raddr,
  output logic [31:0] IMEM_rdata,
  input  logic [31:0] DMEM_addr,
  input  logic [31:0] DMEM_wdata,
  input  logic        DMEM_we,
  input  logic [31:0] fetch_DMEM_addr,
  output logic [31:0] DMEM_rdata,
  output logic        fault,
  output logic [2:0]  fault_code
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam int unsigned ICW = IAW + 1;
  localparam int unsigned DCW = DAW + 1;
  localparam logic [31:0] IMEM_SPAN = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_SPAN = 32'(DMEM_WORDS * 4);

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_OVERFLOW = 3'd1;
  localparam logic [2:0] F_ALIGN    = 3'd2;
  localparam logic [2:0] F_RANGE    = 3'd3;
  localparam logic [2:0] F_MISMATCH = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  logic [31:0] imem_mem [IMEM_WORDS];
  logic [31:0] dmem_mem [DMEM_WORDS];

  state_e           state_q, state_d;
  logic [ICW-1:0]   icnt_q, icnt_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             load_ready_q, load_ready_d;
  logic             cpu_ena_q, cpu_ena_d;
  logic [31:0]      dmem_rdata_q, dmem_rdata_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [31:0]      prev_addr_q, prev_addr_d;
  logic             prev_vld_q, prev_vld_d;

  logic             imem_wr_c;
  logic [IAW-1:0]   imem_widx_c;
  logic             dmem_wr_c;
  logic [DAW-1:0]   dmem_widx_c;
  logic [31:0]      dmem_wdat_c;
  logic             ovf_c, mis_c, rng_c, mm_c;
  logic [2:0]       cause_c;

  logic [31:0]      i_off, d_off;
  logic             i_in_range, d_in_range;
  logic [DAW-1:0]   d_idx;

  assign i_off      = IMEM_raddr - IMEM_BASE;
  assign i_in_range = (i_off < IMEM_SPAN);
  assign d_off      = DMEM_addr - DMEM_BASE;
  assign d_in_range = (d_off < DMEM_SPAN);
  assign d_idx      = d_off[DAW+1:2];

  // Fetch path: out-of-range addresses return a nop.
  assign IMEM_rdata = i_in_range ? imem_mem[i_off[IAW+1:2]] : 32'h0;

  // Next-state, loader, DMEM port and fault cause decode.
  always_comb begin
    state_d      = state_q;
    icnt_d       = icnt_q;
    dcnt_d       = dcnt_q;
    dmem_rdata_d = dmem_rdata_q;
    prev_addr_d  = prev_addr_q;
    prev_vld_d   = prev_vld_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    imem_wr_c    = 1'b0;
    imem_widx_c  = icnt_q[IAW-1:0];
    dmem_wr_c    = 1'b0;
    dmem_widx_c  = d_idx;
    dmem_wdat_c  = DMEM_wdata;
    ovf_c        = 1'b0;
    mis_c        = 1'b0;
    rng_c        = 1'b0;
    mm_c         = 1'b0;
    cause_c      = F_NONE;

    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (load_valid) begin
          if (!load_sel) begin
            if (icnt_q < ICW'(IMEM_WORDS)) begin
              imem_wr_c = 1'b1;
              icnt_d    = icnt_q + ICW'(1);
            end else begin
              ovf_c = 1'b1;
            end
          end else begin
            if (dcnt_q < DCW'(DMEM_WORDS)) begin
              dmem_wr_c   = 1'b1;
              dmem_widx_c = dcnt_q[DAW-1:0];
              dmem_wdat_c = load_data;
              dcnt_d      = dcnt_q + DCW'(1);
            end else begin
              ovf_c = 1'b1;
            end
          end
          if (load_last) state_d = S_RUN;
        end
      end
      S_RUN: begin
        prev_addr_d = DMEM_addr;
        prev_vld_d  = 1'b1;
        mm_c        = prev_vld_q && (fetch_DMEM_addr != prev_addr_q);
        if (!d_in_range) begin
          dmem_rdata_d = 32'h0;
          rng_c        = DMEM_we;
          mis_c        = DMEM_we && (DMEM_addr[1:0] != 2'b00);
        end else if (DMEM_we && (DMEM_addr[1:0] != 2'b00)) begin
          mis_c        = 1'b1;
          dmem_rdata_d = dmem_mem[d_idx];
        end else if (DMEM_we) begin
          dmem_wr_c    = 1'b1;
          dmem_rdata_d = DMEM_wdata;  // write-first
        end else begin
          dmem_rdata_d = dmem_mem[d_idx];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ovf_c)      cause_c = F_OVERFLOW;
    else if (mis_c) cause_c = F_ALIGN;
    else if (rng_c) cause_c = F_RANGE;
    else if (mm_c)  cause_c = F_MISMATCH;

    if (!fault_q && (cause_c != F_NONE)) begin
      fault_d      = 1'b1;
      fault_code_d = cause_c;
    end

    load_ready_d = (state_d == S_LOAD);
    cpu_ena_d    = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      icnt_q       <= '0;
      dcnt_q       <= '0;
      load_ready_q <= 1'b0;
      cpu_ena_q    <= 1'b0;
      dmem_rdata_q <= 32'h0;
      fault_q      <= 1'b0;
      fault_code_q <= F_NONE;
      prev_addr_q  <= 32'h0;
      prev_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      icnt_q       <= icnt_d;
      dcnt_q       <= dcnt_d;
      load_ready_q <= load_ready_d;
      cpu_ena_q    <= cpu_ena_d;
      dmem_rdata_q <= dmem_rdata_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      prev_addr_q  <= prev_addr_d;
      prev_vld_q   <= prev_vld_d;
    end
  end

  // Storage arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (imem_wr_c) imem_mem[imem_widx_c] <= load_data;
    if (dmem_wr_c) dmem_mem[dmem_widx_c] <= dmem_wdat_c;
  end

  assign load_ready = load_ready_q;
  assign cpu_ena    = cpu_ena_q;
  assign DMEM_rdata = dmem_rdata_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized bench for unified_mem_responder with a word-array reference model
// compared every cycle, plus directed literal checks from the boot/run scenarios.
module tb_unified_mem_responder;

  localparam int unsigned IW = 1024;
  localparam int unsigned DW = 1024;
  localparam logic [31:0] IB = 32'h0040_0000;
  localparam logic [31:0] DB = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic        load_last;
  logic [31:0] load_data;
  logic        cpu_ena;
  logic [31:0] IMEM_raddr;
  logic [31:0] IMEM_rdata;
  logic [31:0] DMEM_addr;
  logic [31:0] DMEM_wdata;
  logic        DMEM_we;
  logic [31:0] fetch_DMEM_addr;
  logic [31:0] DMEM_rdata;
  logic        fault;
  logic [2:0]  fault_code;

  unified_mem_responder #(
    .IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_BASE(IB), .DMEM_BASE(DB)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_last(load_last), .load_data(load_data), .cpu_ena(cpu_ena),
    .IMEM_raddr(IMEM_raddr), .IMEM_rdata(IMEM_rdata),
    .DMEM_addr(DMEM_addr), .DMEM_wdata(DMEM_wdata), .DMEM_we(DMEM_we),
    .fetch_DMEM_addr(fetch_DMEM_addr), .DMEM_rdata(DMEM_rdata),
    .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain word arrays, fill counters and a boot phase number.
  logic [31:0] imem_m [IW];
  bit          imem_k [IW];
  logic [31:0] dmem_m [DW];
  bit          dmem_k [DW];
  int          phase = 0;   // 0 = waiting, 1 = loading, 2 = core running
  int          icnt = 0;
  int          dcnt = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_rk = 1'b1;
  bit          m_fault = 1'b0;
  logic [2:0]  m_code = 3'd0;
  logic [31:0] m_prev = 32'h0;
  bit          m_pvld = 1'b0;

  function automatic int lowest(input int cur, input int c);
    return (cur == 0 || c < cur) ? c : cur;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    logic [31:0] off;
    int cause;
    int idx;
    if (!reset) begin
      phase = 0; icnt = 0; dcnt = 0;
      m_rdata = 32'h0; m_rk = 1'b1;
      m_fault = 1'b0; m_code = 3'd0;
      m_prev = 32'h0; m_pvld = 1'b0;
    end else begin
      cause = 0;
      if (phase == 0) begin
        phase = 1;
      end else if (phase == 1) begin
        if (load_valid) begin
          if (!load_sel) begin
            if (icnt < IW) begin imem_m[icnt] = load_data; imem_k[icnt] = 1'b1; icnt++; end
            else cause = lowest(cause, 1);
          end else begin
            if (dcnt < DW) begin dmem_m[dcnt] = load_data; dmem_k[dcnt] = 1'b1; dcnt++; end
            else cause = lowest(cause, 1);
          end
          if (load_last) phase = 2;
        end
      end else begin
        if (m_pvld && fetch_DMEM_addr != m_prev) cause = lowest(cause, 4);
        m_prev = DMEM_addr;
        m_pvld = 1'b1;
        off = DMEM_addr - DB;
        idx = int'(off[31:2]);
        if (off >= 4 * DW) begin
          m_rdata = 32'h0; m_rk = 1'b1;
          if (DMEM_we) cause = lowest(cause, 3);
          if (DMEM_we && DMEM_addr[1:0] != 2'b00) cause = lowest(cause, 2);
        end else if (DMEM_we && DMEM_addr[1:0] != 2'b00) begin
          cause = lowest(cause, 2);
          m_rdata = dmem_m[idx]; m_rk = dmem_k[idx];
        end else begin
          if (DMEM_we) begin dmem_m[idx] = DMEM_wdata; dmem_k[idx] = 1'b1; end
          m_rdata = dmem_m[idx]; m_rk = dmem_k[idx];
        end
      end
      if (cause != 0 && !m_fault) begin
        m_fault = 1'b1;
        m_code = 3'(cause);
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin : compare
    logic [31:0] ioff;
    int ii;
    check("load_ready", 32'(load_ready), 32'(phase == 1));
    check("cpu_ena", 32'(cpu_ena), 32'(phase == 2));
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_code", 32'(fault_code), 32'(m_code));
    if (m_rk) check("DMEM_rdata", DMEM_rdata, m_rdata);
    ioff = IMEM_raddr - IB;
    if (ioff < 4 * IW) begin
      ii = int'(ioff[31:2]);
      if (imem_k[ii]) check("IMEM_rdata", IMEM_rdata, imem_m[ii]);
    end else begin
      check("IMEM_rdata_oor", IMEM_rdata, 32'h0);
    end
  end

  logic [31:0] last_addr = 32'h0;

  task automatic junk_core_inputs();
    DMEM_we         = 1'($urandom);
    DMEM_addr       = DB + 32'(4 * $urandom_range(0, 15));
    DMEM_wdata      = $urandom;
    fetch_DMEM_addr = $urandom;
    IMEM_raddr      = IB + 32'(4 * $urandom_range(0, 7));
  endtask

  task automatic load_word(input bit sel, input logic [31:0] d, input bit last);
    int n;
    if ($urandom_range(0, 3) == 0) begin
      load_valid = 1'b0; load_sel = 1'($urandom); load_last = 1'($urandom);
      load_data = $urandom; junk_core_inputs();
      @(posedge clk); #2;
    end
    load_valid = 1'b1; load_sel = sel; load_last = last; load_data = d;
    junk_core_inputs();
    n = 0;
    while (!load_ready && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL load_ready_timeout: got load_ready=0 expected 1 within 20 cycles at %0t", $time);
    end
    @(posedge clk); #2;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input bit we, input logic [31:0] wd, input bit mism);
    load_valid      = 1'b0;
    fetch_DMEM_addr = mism ? ~last_addr : last_addr;
    DMEM_addr       = a;
    DMEM_we         = we;
    DMEM_wdata      = wd;
    IMEM_raddr      = ($urandom_range(0, 7) == 0) ? 32'h0000_1000 : IB + 32'(4 * $urandom_range(0, 7));
    last_addr       = a;
    @(posedge clk); #2;
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0)
        run_op(32'h2000_0000 + 32'(4 * $urandom_range(0, 3)), 1'b0, $urandom, 1'b0);
      else
        run_op(DB + 32'(4 * $urandom_range(0, 15)), 1'($urandom), $urandom, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic imem_peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    IMEM_raddr = a;
    #1;
    check(name, IMEM_rdata, exp);
  endtask

  logic [31:0] w_first, w_last, w0, w1, w2;

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_last = 1'b0; load_data = 32'h0;
    IMEM_raddr = 32'h0; DMEM_addr = 32'h0; DMEM_wdata = 32'h0; DMEM_we = 1'b0;
    fetch_DMEM_addr = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cpu_ena", 32'(cpu_ena), 32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h0);
    check("rst_DMEM_rdata", DMEM_rdata, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_code", 32'(fault_code), 32'h0);
    reset = 1'b1;

    // Basic boot: two IMEM words then the last word into DMEM.
    load_word(1'b0, 32'h2008_0005, 1'b0);
    load_word(1'b0, 32'h2009_0003, 1'b0);
    check("boot_cpu_ena_before_last", 32'(cpu_ena), 32'h0);
    load_word(1'b1, 32'hDEAD_BEEF, 1'b1);
    check("boot_cpu_ena_after_last", 32'(cpu_ena), 32'h1);
    check("boot_load_ready_after_last", 32'(load_ready), 32'h0);
    imem_peek("imem_word1", 32'h0040_0004, 32'h2009_0003);
    imem_peek("imem_word0", 32'h0040_0000, 32'h2008_0005);
    imem_peek("imem_oor_nop", 32'h0000_0000, 32'h0);
    run_op(DB, 1'b0, 32'h0, 1'b0);
    check("dmem_boot_word", DMEM_rdata, 32'hDEAD_BEEF);

    rand_run(200);

    run_op(32'h1001_0010, 1'b1, 32'h1234_5678, 1'b0);
    run_op(32'h1001_0010, 1'b0, 32'h0, 1'b0);
    check("store_then_load", DMEM_rdata, 32'h1234_5678);
    run_op(32'h1001_0000, 1'b1, 32'hA5A5_A5A5, 1'b0);
    check("write_first", DMEM_rdata, 32'hA5A5_A5A5);
    check("no_fault_yet", 32'(fault), 32'h0);
    run_op(32'h1001_0002, 1'b1, 32'h5555_5555, 1'b0);
    check("misaligned_fault", 32'(fault), 32'h1);
    check("misaligned_code", 32'(fault_code), 32'h2);
    run_op(32'h1001_0000, 1'b0, 32'h0, 1'b0);
    check("misaligned_no_write", DMEM_rdata, 32'hA5A5_A5A5);
    run_op(32'h2000_0000, 1'b1, 32'h7777_7777, 1'b0);
    check("oor_rdata_zero", DMEM_rdata, 32'h0);
    check("oor_keeps_code2", 32'(fault_code), 32'h2);
    rand_run(50);

    // IMEM overflow: one word beyond the depth is dropped.
    do_reset();
    for (int i = 0; i < int'(IW); i++) begin
      w2 = $urandom;
      if (i == 0) w_first = w2;
      if (i == int'(IW) - 1) w_last = w2;
      load_word(1'b0, w2, 1'b0);
    end
    check("ovf_no_fault_at_depth", 32'(fault), 32'h0);
    load_word(1'b0, 32'hFFFF_0000, 1'b1);
    check("ovf_fault", 32'(fault), 32'h1);
    check("ovf_code", 32'(fault_code), 32'h1);
    check("ovf_cpu_ena", 32'(cpu_ena), 32'h1);
    imem_peek("ovf_imem0_kept", IB, w_first);
    imem_peek("ovf_imem_top", IB + 32'(4 * (IW - 1)), w_last);
    rand_run(30);

    // Reset mid-load, then reload a single word.
    do_reset();
    w0 = 32'h1111_0000 ^ $urandom;
    w1 = 32'h2222_0000 ^ $urandom;
    w2 = 32'h3333_0000 ^ $urandom;
    load_word(1'b0, w0, 1'b0);
    load_word(1'b0, w1, 1'b0);
    do_reset();
    check("midload_rst_cpu_ena", 32'(cpu_ena), 32'h0);
    load_word(1'b0, w2, 1'b1);
    check("reload_cpu_ena", 32'(cpu_ena), 32'h1);
    check("reload_fault", 32'(fault), 32'h0);
    imem_peek("reload_imem0_new", IB, w2);
    imem_peek("reload_imem1_old", IB + 32'd4, w1);
    rand_run(100);
    run_op(DB + 32'd6, 1'b1, 32'h0, 1'b1);
    check("simultaneous_lowest_code", 32'(fault_code), 32'h2);

    // Address consistency: ignored on the first RUN cycle, flagged after.
    do_reset();
    load_word(1'b1, 32'h0BAD_F00D, 1'b1);
    run_op(DB, 1'b0, 32'h0, 1'b1);
    check("mm_first_cycle_ignored", 32'(fault), 32'h0);
    check("mm_first_cycle_rdata", DMEM_rdata, 32'h0BAD_F00D);
    run_op(DB + 32'd4, 1'b0, 32'h0, 1'b1);
    check("mm_fault", 32'(fault), 32'h1);
    check("mm_code", 32'(fault_code), 32'h4);
    rand_run(20);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_responder.md
# unified_mem_responder

Memory-side responder for the five-stage MIPS core: holds instruction and data storage, answers the core's IMEM fetch port (combinational) and DMEM block-memory port (one-cycle registered read, synchronous write). After reset it runs a boot-load state machine that fills both memories from a valid/ready word stream, then asserts `cpu_ena` to release the core. It sits at the top level beside the CPU, wired port-for-port to its IMEM/DMEM signals.

## Interface
- `IMEM_WORDS`, 1024, instruction memory depth in 32-bit words (power of two)
- `DMEM_WORDS`, 1024, data memory depth in 32-bit words (power of two)
- `IMEM_BASE`, 32'h0040_0000, byte address of IMEM word 0
- `DMEM_BASE`, 32'h1001_0000, byte address of DMEM word 0
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state
- `load_valid`  in  1  boot word present
- `load_ready`  out  1  boot word accepted when high with `load_valid`
- `load_sel`  in  1  0 = word targets IMEM, 1 = DMEM
- `load_last`  in  1  marks final boot word
- `load_data`  in  32  boot word
- `cpu_ena`  out  1  core enable; high only in RUN
- `IMEM_raddr`  in  32  fetch byte address
- `IMEM_rdata`  out  32  fetched instruction, combinational
- `DMEM_addr`  in  32  EXE-stage byte address
- `DMEM_wdata`  in  32  store data
- `DMEM_we`  in  1  store strobe
- `fetch_DMEM_addr`  in  32  MEM-stage address, consistency check only
- `DMEM_rdata`  out  32  registered load data
- `fault`  out  1  sticky error flag
- `fault_code`  out  3  first fault cause: 1 load overflow, 2 misaligned, 3 out of range, 4 addr mismatch

## Operation
- States: IDLE -> LOAD -> RUN. Reset forces IDLE. IDLE -> LOAD unconditionally on next edge. LOAD -> RUN on the edge accepting a word with `load_last`=1. RUN is terminal until reset.
- LOAD: `load_ready`=1. Accepted word written to IMEM[icnt] (sel 0) or DMEM[dcnt] (sel 1); that counter increments. Counters are `$clog2(depth)+1` bits; word at count == depth is dropped, fault code 1, load continues.
- Counters clear only on reset. Memory arrays are never cleared by reset.
- Index: idx = (addr − BASE) >> 2. In range iff (addr − BASE) < 4·depth (unsigned).
- IMEM read: `IMEM_rdata` = IMEM[idx] combinationally; out of range returns 32'h0 (nop), no fault.
- DMEM port active only in RUN; ignored in IDLE/LOAD (no write, `DMEM_rdata` holds).
- DMEM access every RUN cycle: at edge, `DMEM_rdata` <= mem[idx]; if `DMEM_we`, mem[idx] <= `DMEM_wdata`. Read-during-write same index returns new data (write-first).
- `DMEM_addr[1:0]` ≠ 0 with `DMEM_we`: write suppressed, fault code 2. Out-of-range: write suppressed, `DMEM_rdata` <= 0, fault code 3 (only if `DMEM_we`; reads silent).
- Consistency: registered copy of previous-cycle `DMEM_addr`; in RUN, if `fetch_DMEM_addr` ≠ that copy and the copy is valid (second RUN cycle onward), fault code 4.
- `fault` sets on first cause, stays until reset; `fault_code` latches first cause only; simultaneous causes record lowest code.

## Timing
- Reset values: state IDLE, `cpu_ena` 0, `load_ready` 0, `DMEM_rdata` 0, `fault` 0, `fault_code` 0, counters 0.
- `load_ready`, `cpu_ena` decoded from registered state (no combinational path from inputs).
- `cpu_ena` rises the cycle after `load_last` is accepted; `load_ready` falls same cycle.
- DMEM read latency 1 cycle: address at edge N, data valid after edge N, matching the core sampling in MEM stage.
- IMEM read latency 0.
- Reset low mid-LOAD: immediate return to IDLE, partial load contents retained, counters zero; reload overwrites from word 0.
- Boot words sent with `load_valid` low are ignored; `load_valid` may stay high across cycles (one word per cycle).

## Test plan
- Reset then stream IMEM words 32'h2008_0005, 32'h2009_0003, last to DMEM 32'hDEAD_BEEF -> `cpu_ena` 0 until edge after third accept, then 1; IMEM_raddr 32'h0040_0004 gives 32'h2009_0003.
- RUN: store 32'h1234_5678 at 32'h1001_0010, next cycle read same -> `DMEM_rdata` 32'h1234_5678 one cycle after read address.
- Same-cycle write/read at 32'h1001_0000 with wdata 32'hA5A5_A5A5 -> `DMEM_rdata` A5A5_A5A5 next cycle (write-first).
- Store to 32'h1001_0002 -> no write, `fault`=1, code 2; later out-of-range store keeps code 2.
- Send IMEM_WORDS+1 IMEM words -> last dropped, code 1, IMEM[0] unchanged.
- Assert reset mid-load after 2 words, reload 1 word with last -> IMEM[0] new, IMEM[1] retains old, `cpu_ena` 1.
